// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared FSM state encoding and counter-width helper for the
//                pushbutton debounce controller.
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

   // Per-channel debounce FSM states (explicit 2-bit encoding)
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   // Bits needed to hold values 0..max_count
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_controller_if
//  Description : Button-side bundle: raw inputs in, debounced level and
//                press/release event pulses out.
//  Revision    : 1.0  initial release
// ============================================================================
interface debounce_controller_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] InSignal;
   logic [N_CH-1:0] Level;
   logic [N_CH-1:0] Press;
   logic [N_CH-1:0] Release;

   // Board / stimulus side drives the raw buttons
   modport master (output InSignal, input Level, input Press, input Release);
   // Debounce controller side
   modport slave  (input InSignal, output Level, output Press, output Release);
endinterface
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One button channel: synchronizer chain, debounce FSM with
//                stability counter, registered level and one-cycle pulses.
//                Optional auto-repeat of Press while held, enabled by the
//                AUTOREPEAT_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   db_state_t              state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic                   level_nx, press_nx, release_nx;
   logic                   accept_press, accept_release;
   logic                   repeat_fire;

   assign sync_q = sync_r[SYNC_STAGES-1];

   // Shift the raw button through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_r <= '0;
      else        sync_r <= {sync_r[SYNC_STAGES-2:0], button};
   end

   // State register plus registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         level         <= level_nx;
         press         <= press_nx;
         release_pulse <= release_nx;
      end
   end

   // Next-state and stability counter; every count path ends at CNT_LAST
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (sync_q) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = CW'(1);
            end else begin
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_q) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync_q) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = CW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (sync_q) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Output decode: pulses on accepted transitions, level follows held states
   always_comb begin
      accept_press   = (state == PRESS_WAIT)   &&  sync_q && (cnt == CNT_LAST);
      accept_release = (state == RELEASE_WAIT) && !sync_q && (cnt == CNT_LAST);
      level_nx       = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
      press_nx       = accept_press | repeat_fire;
      release_nx     = accept_release;
   end

`ifdef AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = cnt_width(RPT_MAX);

   logic [RW-1:0] rpt_cnt, rpt_cnt_nx;
   logic          rpt_armed, rpt_armed_nx;

   // Repeat timer only runs while PRESSED and still held; any exit clears it
   always_comb begin
      rpt_cnt_nx   = '0;
      rpt_armed_nx = 1'b0;
      repeat_fire  = 1'b0;
      if ((state == PRESSED) && sync_q) begin
         rpt_armed_nx = rpt_armed;
         rpt_cnt_nx   = rpt_cnt + 1'b1;
         if (!rpt_armed && (rpt_cnt == RW'(REPEAT_DELAY - 1))) begin
            repeat_fire  = 1'b1;
            rpt_armed_nx = 1'b1;
            rpt_cnt_nx   = '0;
         end else if (rpt_armed && (rpt_cnt == RW'(REPEAT_PERIOD - 1))) begin
            repeat_fire  = 1'b1;
            rpt_cnt_nx   = '0;
         end
      end
   end

   // Repeat timer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else begin
         rpt_cnt   <= rpt_cnt_nx;
         rpt_armed <= rpt_armed_nx;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/debounce_controller.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_controller
//  Description : N_CH independent pushbutton conditioners (sync + debounce
//                + press/release pulses). Auto-repeat of Press is available
//                when built with the AUTOREPEAT_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_controller
   import debounce_pkg::*;
#(
   parameter int N_CH            = 4,
   parameter int SYNC_STAGES     = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   debounce_controller_if.slave bus
);

   // One fully independent conditioner per button
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk           (Clk),
         .rst_n         (Reset_n),
         .button        (bus.InSignal[i]),
         .level         (bus.Level[i]),
         .press         (bus.Press[i]),
         .release_pulse (bus.Release[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_debounce_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_controller
//  Description : Directed self-checking bench for debounce_controller with
//                default parameters (3 sync stages, 16 debounce cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_controller;

   logic Clk = 1'b0;
   logic Reset_n;
   int   tests = 0;
   int   fails = 0;

   debounce_controller_if #(.N_CH(4)) bus ();

   debounce_controller #(
      .N_CH            (4),
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (16),
      .REPEAT_DELAY    (64),
      .REPEAT_PERIOD   (16)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Watch one channel for n edges: expect exactly one pulse of the chosen
   // kind at edge exp_at (0 = none) and no pulse of the opposite kind.
   task automatic watch(input string tag, input int n, input int ch,
                        input bit is_press, input int exp_at);
      int first = 0;
      int hits  = 0;
      int other = 0;
      for (int e = 1; e <= n; e++) begin
         tick();
         if ((is_press ? bus.Press[ch] : bus.Release[ch]) === 1'b1) begin
            hits++;
            if (first == 0) first = e;
         end
         if ((is_press ? bus.Release[ch] : bus.Press[ch]) === 1'b1) other++;
      end
      check({tag, " edge"},  first, exp_at);
      check({tag, " count"}, hits,  (exp_at != 0) ? 1 : 0);
      check({tag, " other"}, other, 0);
   endtask

   // Watch the whole vector: first edge any bit pulses and the vector then
   task automatic vec_watch(input string tag, input int n, input bit is_press,
                            input int exp_at, input logic [3:0] exp_vec);
      int         first = 0;
      logic [3:0] val   = 4'h0;
      logic [3:0] cur;
      for (int e = 1; e <= n; e++) begin
         tick();
         cur = is_press ? bus.Press : bus.Release;
         if (first == 0 && cur != 4'h0) begin
            first = e;
            val   = cur;
         end
      end
      check({tag, " edge"},   first, exp_at);
      check({tag, " vector"}, val,   exp_vec);
   endtask

   initial begin
      logic [3:0] any_pulse;
      int         acc;

      // ---------------- reset behaviour ----------------
      Reset_n      = 1'b0;
      bus.InSignal = 4'h0;
      for (int i = 0; i < 4; i++) begin
         bus.InSignal = 4'(i * 5 + 3);
         tick();
         check("rst level",   bus.Level,   4'h0);
         check("rst press",   bus.Press,   4'h0);
         check("rst release", bus.Release, 4'h0);
      end
      bus.InSignal = 4'h0;
      tick();
      Reset_n = 1'b1;
      any_pulse = 4'h0;
      for (int i = 0; i < 25; i++) begin
         tick();
         any_pulse = any_pulse | bus.Press | bus.Release;
      end
      check("post-reset pulses", any_pulse, 4'h0);

      // ---------------- clean press ch0 ----------------
      bus.InSignal[0] = 1'b1;
      watch("ch0 press", 40, 0, 1'b1, 19);
      check("ch0 level high", bus.Level, 4'b0001);

      // ---------------- glitch ch1 ----------------
      bus.InSignal[1] = 1'b1;
      repeat (10) tick();
      bus.InSignal[1] = 1'b0;
      watch("ch1 glitch", 40, 1, 1'b1, 0);
      check("ch1 level after glitch", bus.Level[1], 1'b0);
      // Counter must restart from scratch after the glitch
      bus.InSignal[1] = 1'b1;
      watch("ch1 press after glitch", 30, 1, 1'b1, 19);
      check("ch1 level pressed", bus.Level[1], 1'b1);
      bus.InSignal[1] = 1'b0;
      watch("ch1 release", 30, 1, 1'b0, 19);
      check("ch1 level released", bus.Level[1], 1'b0);

      // ---------------- release bounce ch0 ----------------
      acc = 0;
      bus.InSignal[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         acc += int'(bus.Release[0]);
`ifndef AUTOREPEAT_EN
         acc += int'(bus.Press[0]);
`endif
      end
      bus.InSignal[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         acc += int'(bus.Release[0]);
`ifndef AUTOREPEAT_EN
         acc += int'(bus.Press[0]);
`endif
      end
      check("ch0 bounce pulses", acc, 0);
      bus.InSignal[0] = 1'b0;
      watch("ch0 release", 30, 0, 1'b0, 19);
      check("ch0 level released", bus.Level, 4'h0);

      // ---------------- simultaneous channels ----------------
      bus.InSignal = 4'hF;
      vec_watch("all press", 25, 1'b1, 19, 4'hF);
      check("all level high", bus.Level, 4'hF);
      bus.InSignal = 4'h0;
      vec_watch("all release", 25, 1'b0, 19, 4'hF);
      check("all level low", bus.Level, 4'h0);

      // ---------------- reset mid PRESS_WAIT, inputs low on exit ----------------
      bus.InSignal = 4'hF;
      repeat (8) tick();
      Reset_n = 1'b0;
      bus.InSignal = 4'h0;
      repeat (2) tick();
      Reset_n = 1'b1;
      vec_watch("reset abort", 30, 1'b1, 0, 4'h0);

      // ---------------- reset mid PRESS_WAIT, inputs held: full restart ----------------
      bus.InSignal = 4'hF;
      repeat (4) tick();
      Reset_n = 1'b0;
      repeat (2) tick();
      Reset_n = 1'b1;
      vec_watch("restart press", 25, 1'b1, 19, 4'hF);
      check("restart level", bus.Level, 4'hF);

      // ---------------- asynchronous reset between edges ----------------
      #2;
      Reset_n = 1'b0;
      #1;
      check("async level clear", bus.Level, 4'h0);
      bus.InSignal = 4'h0;
      tick();
      tick();
      Reset_n = 1'b1;
      vec_watch("async exit press", 25, 1'b1, 0, 4'h0);
      vec_watch("async exit release", 5, 1'b0, 0, 4'h0);

`ifdef AUTOREPEAT_EN
      // ---------------- auto-repeat ch2 ----------------
      begin
         int  mism = 0;
         int  hits = 0;
         bit  exp;
         bus.InSignal[2] = 1'b1;
         for (int e = 1; e <= 200; e++) begin
            tick();
            exp = (e == 19) || (e >= 83 && ((e - 83) % 16) == 0);
            if (bus.Press[2] !== exp) mism++;
            if (bus.Press[2] === 1'b1) hits++;
         end
         check("repeat timing mismatches", mism, 0);
         check("repeat pulse count", hits, 9);
         bus.InSignal[2] = 1'b0;
         watch("ch2 release after repeat", 30, 2, 1'b0, 19);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
